// File: rtl/program_loader.sv
// -----------------------------------------------------------------------------
// program_loader
//
// Purpose:
//   Fills the MiniAlu instruction RAM from a byte stream at power-up and keeps
//   the CPU in reset until a checksum-verified image has been written.
//   Stream layout: count low byte, count high byte (N, little-endian), then N
//   words of 4 bytes each (little-endian), then one XOR checksum byte covering
//   every byte from the count low byte through the last data byte.
//
// Ports:
//   Clock          in   system clock, rising edge
//   Reset          in   asynchronous, active-low reset
//   iStart         in   pulse that begins a load (accepted in IDLE/DONE/ERROR)
//   iByte          in   stream byte
//   iByteValid     in   iByte is valid
//   oByteReady     out  loader accepts a byte this cycle
//   oWriteEnable   out  instruction RAM write strobe, one cycle per word
//   oWriteAddress  out  instruction RAM write address
//   oWriteData     out  instruction word
//   oCpuReset      out  high holds the CPU in reset
//   oBusy          out  high while a load is in progress
//   oDone          out  load completed with a good checksum
//   oError         out  load failed
//   oWordCount     out  word count N received in the header
// -----------------------------------------------------------------------------
module program_loader #(
  parameter int ADDR_WIDTH = 16,
  parameter int INSN_WIDTH = 28,
  parameter int MAX_WORDS  = 256
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  iStart,
  input  logic [7:0]            iByte,
  input  logic                  iByteValid,
  output logic                  oByteReady,
  output logic                  oWriteEnable,
  output logic [ADDR_WIDTH-1:0] oWriteAddress,
  output logic [INSN_WIDTH-1:0] oWriteData,
  output logic                  oCpuReset,
  output logic                  oBusy,
  output logic                  oDone,
  output logic                  oError,
  output logic [15:0]           oWordCount
);

  typedef enum logic [2:0] {
    IDLE,
    CNT_LO,
    CNT_HI,
    DATA,
    CHECK,
    DONE,
    ERROR
  } stateT;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  stateT                 state, stateNext;
  logic [7:0]            countLow, countLowNext;
  logic [1:0]            byteIndex, byteIndexNext;
  logic [23:0]           wordBuf, wordBufNext;
  logic [7:0]            checksum, checksumNext;

  logic                  byteReadyNext;
  logic                  writeEnableNext;
  logic [ADDR_WIDTH-1:0] writeAddressNext;
  logic [INSN_WIDTH-1:0] writeDataNext;
  logic                  cpuResetNext;
  logic                  busyNext;
  logic                  doneNext;
  logic                  errorNext;
  logic [15:0]           wordCountNext;

  logic                  transfer;
  logic [15:0]           headerCount;
  logic [31:0]           fullWord;
  logic                  upperBitsSet;
  logic                  lastWord;

  assign transfer     = iByteValid && oByteReady;
  assign headerCount  = {iByte, countLow};
  assign fullWord     = {iByte, wordBuf};
  // Any bit above the instruction width makes the word unloadable.
  assign upperBitsSet = (fullWord >> INSN_WIDTH) != 32'd0;
  // The address register still holds this word's index when its last byte
  // arrives, because the previous increment happened several cycles earlier.
  assign lastWord     = (32'(oWriteAddress) + 32'd1) == 32'(oWordCount);

  // State and all outputs are registered together; everything is computed
  // as a next value below so the outputs never carry combinational paths.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state         <= IDLE;
      countLow      <= 8'd0;
      byteIndex     <= 2'd0;
      wordBuf       <= 24'd0;
      checksum      <= 8'd0;
      oByteReady    <= 1'b0;
      oWriteEnable  <= 1'b0;
      oWriteAddress <= '0;
      oWriteData    <= '0;
      oCpuReset     <= 1'b1;
      oBusy         <= 1'b0;
      oDone         <= 1'b0;
      oError        <= 1'b0;
      oWordCount    <= 16'd0;
    end else begin
      state         <= stateNext;
      countLow      <= countLowNext;
      byteIndex     <= byteIndexNext;
      wordBuf       <= wordBufNext;
      checksum      <= checksumNext;
      oByteReady    <= byteReadyNext;
      oWriteEnable  <= writeEnableNext;
      oWriteAddress <= writeAddressNext;
      oWriteData    <= writeDataNext;
      oCpuReset     <= cpuResetNext;
      oBusy         <= busyNext;
      oDone         <= doneNext;
      oError        <= errorNext;
      oWordCount    <= wordCountNext;
    end
  end

  // Next-state and next-output logic. The write strobe lasts exactly one
  // cycle, and the address advances on the edge that ends that strobe, so
  // the RAM sees the address of the word being written.
  always_comb begin
    stateNext        = state;
    countLowNext     = countLow;
    byteIndexNext    = byteIndex;
    wordBufNext      = wordBuf;
    checksumNext     = checksum;
    writeEnableNext  = 1'b0;
    writeAddressNext = oWriteEnable ? (oWriteAddress + ADDR_ONE) : oWriteAddress;
    writeDataNext    = oWriteData;
    cpuResetNext     = oCpuReset;
    busyNext         = oBusy;
    doneNext         = oDone;
    errorNext        = oError;
    wordCountNext    = oWordCount;

    case (state)
      IDLE, DONE, ERROR: begin
        if (iStart) begin
          stateNext        = CNT_LO;
          writeAddressNext = '0;
          checksumNext     = 8'd0;
          byteIndexNext    = 2'd0;
          wordCountNext    = 16'd0;
          busyNext         = 1'b1;
          doneNext         = 1'b0;
          errorNext        = 1'b0;
          cpuResetNext     = 1'b1;
        end
      end

      CNT_LO: begin
        if (transfer) begin
          countLowNext = iByte;
          checksumNext = checksum ^ iByte;
          stateNext    = CNT_HI;
        end
      end

      CNT_HI: begin
        if (transfer) begin
          checksumNext  = checksum ^ iByte;
          wordCountNext = headerCount;
          byteIndexNext = 2'd0;
          if (32'(headerCount) > 32'(MAX_WORDS)) begin
            stateNext = ERROR;
            busyNext  = 1'b0;
            errorNext = 1'b1;
          end else if (headerCount == 16'd0) begin
            stateNext = CHECK;
          end else begin
            stateNext = DATA;
          end
        end
      end

      DATA: begin
        if (transfer) begin
          checksumNext = checksum ^ iByte;
          if (byteIndex != 2'd3) begin
            case (byteIndex)
              2'd0:    wordBufNext[7:0]   = iByte;
              2'd1:    wordBufNext[15:8]  = iByte;
              default: wordBufNext[23:16] = iByte;
            endcase
            byteIndexNext = byteIndex + 2'd1;
          end else begin
            byteIndexNext = 2'd0;
            if (upperBitsSet) begin
              stateNext = ERROR;
              busyNext  = 1'b0;
              errorNext = 1'b1;
            end else begin
              writeEnableNext = 1'b1;
              writeDataNext   = fullWord[INSN_WIDTH-1:0];
              // Leaving DATA right away keeps the checksum byte from being
              // taken as data while the final write is still in flight.
              if (lastWord) begin
                stateNext = CHECK;
              end
            end
          end
        end
      end

      CHECK: begin
        if (transfer) begin
          busyNext = 1'b0;
          if (iByte == checksum) begin
            stateNext    = DONE;
            doneNext     = 1'b1;
            cpuResetNext = 1'b0;
          end else begin
            stateNext = ERROR;
            errorNext = 1'b1;
          end
        end
      end

      default: begin
        stateNext = IDLE;
      end
    endcase

    byteReadyNext = (stateNext == CNT_LO) || (stateNext == CNT_HI) ||
                    (stateNext == DATA)   || (stateNext == CHECK);
  end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Fills the MiniAlu instruction memory at power-up, and holds the CPU in reset until the load is complete.
- Byte stream in, 28-bit instruction words out, written to incrementing addresses.
- Sits between the host byte link (UART receiver or test bench) and the write port of the instruction RAM that replaces the fixed ROM.
- Releases the CPU reset only after a checksum-verified image has been written.

Parameters:
ADDR_WIDTH, 16, instruction address width (matches IP width)
INSN_WIDTH, 28, instruction word width
MAX_WORDS, 256, largest word count accepted

Ports:
Clock  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-low reset
iStart  in  1  single-cycle pulse: begin a load; accepted in IDLE, DONE or ERROR
iByte  in  8  stream byte
iByteValid  in  1  iByte is valid
oByteReady  out  1  loader accepts a byte this cycle
oWriteEnable  out  1  instruction RAM write strobe, one cycle per word
oWriteAddress  out  ADDR_WIDTH  write address
oWriteData  out  INSN_WIDTH  instruction word
oCpuReset  out  1  high holds the CPU in reset
oBusy  out  1  high while a load is in progress
oDone  out  1  load completed with a good checksum
oError  out  1  load failed
oWordCount  out  16  word count N received in the header

Behaviour:
- Reset (async, Reset=0):
  - state=IDLE, oCpuReset=1.
  - All other outputs 0, including oWriteAddress=0 and oWordCount=0.
  - Internal byte index and checksum are cleared.
- Reset mid-load: same as above. The partial image is abandoned and the address restarts at 0 on the next load.
- Transfer rule: a byte transfers on the rising edge where iByteValid=1 and oByteReady=1. Idle cycles with iByteValid=0 are legal anywhere in the stream.
- oByteReady=1 only in CNT_LO, CNT_HI, DATA and CHECK. All outputs are registered.
- Stream format:
  - Count low byte, then count high byte (N, little-endian).
  - Then N words, 4 bytes each, little-endian.
  - Then 1 checksum byte.
- Checksum: running XOR of every byte from the count low byte through the last data byte. It is cleared on iStart.
- FSM states and transitions:
  - IDLE: on iStart go to CNT_LO. Clear the address, checksum and byte index. Set oBusy=1, oDone=0, oError=0, oCpuReset=1.
  - CNT_LO: on transfer, latch N[7:0] and go to CNT_HI.
  - CNT_HI: on transfer, latch N[15:8] and update oWordCount.
    - If N > MAX_WORDS, go to ERROR.
    - Else if N == 0, go to CHECK.
    - Else go to DATA.
  - DATA: the byte index counts 0..3 and fills the word LSB first.
    - On the 4th byte, if bits 31:28 != 0, go to ERROR with no write.
    - Otherwise, in the next cycle: oWriteEnable=1 for one cycle, oWriteData=word[27:0], oWriteAddress=current address. The address then increments.
    - After the write of word N-1, go to CHECK. Otherwise stay in DATA with the index at 0.
    - The write cycle may overlap acceptance of the next byte.
  - CHECK: on transfer, compare the received byte with the XOR.
    - Equal: go to DONE.
    - Different: go to ERROR.
  - DONE: oDone=1, oBusy=0, oCpuReset=0.
    - If the checksum byte transfers at edge T, oCpuReset is low from T+1.
    - iStart in DONE re-enters CNT_LO with oCpuReset=1 in the next cycle.
  - ERROR: oError=1, oBusy=0, oCpuReset=1, oByteReady=0. Leave only on iStart, which goes to CNT_LO.
- Words already written before an error stay written. No rollback.
- iStart during CNT_LO, CNT_HI, DATA or CHECK is ignored.
- Addresses run from 0 to N-1. No wrap is possible because N ≤ MAX_WORDS ≤ 2^ADDR_WIDTH.
- oWordCount holds its value until the next iStart or reset.

Test Plan:
1. Reset low, then high, with no stimulus -> oCpuReset=1; oByteReady, oBusy, oDone, oError, oWriteEnable all 0; oWriteAddress=0.
2. iStart, then bytes 02 00 | 05 00 01 03 | 00 00 00 07 | 02 -> two write pulses, (addr 0, data 28'h3010005) then (addr 1, data 28'h7000000); oWordCount=2; oDone=1 and oCpuReset=0 one cycle after the checksum byte.
3. Same stream as 2 with checksum 03 and random iByteValid gaps -> both writes still occur; oError=1; oCpuReset stays 1; oByteReady=0; a following iStart with the good stream reaches DONE.
4. iStart, then bytes 00 00 00 -> no write pulses; DONE one cycle after the third byte; oCpuReset=0.
5. iStart, then bytes 01 01 (N=257 > 256) -> ERROR right after the second byte, oWordCount=257, no writes.
6. iStart, then bytes 01 00 00 00 00 10 -> ERROR, no write (nonzero top nibble); then iStart, bytes 01 00 AA, and Reset low while in DATA -> IDLE, oWriteAddress=0, oCpuReset=1.
